// File: rtl/seg_scan_driver.sv
// 8-digit common-anode 7-segment scan driver with frame-synchronous update
// buffering and per-slot anti-ghosting blanking.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] string_i,
  input  logic [7:0]  dp_in_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_n_o,
  output logic        frame_done_o
);

  localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_str_q, shadow_str_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic [31:0] active_str_q, active_str_d;
  logic [7:0]  active_dp_q, active_dp_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        fd_q, fd_d;

  logic        tick;
  logic        boundary;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    boundary = tick && (idx_q == 3'd7);
    nibble   = active_str_q[{idx_q, 2'b00} +: 4];

    cnt_d        = tick ? '0 : cnt_q + 16'd1;
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    pending_d    = pending_q;
    shadow_str_d = shadow_str_q;
    shadow_dp_d  = shadow_dp_q;
    active_str_d = active_str_q;
    active_dp_d  = active_dp_q;
    fd_d         = boundary;

    // Commit uses the pre-load shadow; a coincident load re-arms pending below.
    if (boundary && pending_q) begin
      active_str_d = shadow_str_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end
    if (load_i) begin
      shadow_str_d = string_i;
      shadow_dp_d  = dp_in_i;
      pending_d    = 1'b1;
    end

    if (cnt_q < BLANK_END) begin
      an_d   = '1;
      seg_d  = '1;
      dp_n_d = 1'b1;
    end else begin
      an_d   = ~(8'b1 << idx_q);
      seg_d  = hex7(nibble);
      dp_n_d = ~active_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      shadow_str_q <= '0;
      shadow_dp_q  <= '0;
      active_str_q <= '0;
      active_dp_q  <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_n_q       <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_str_q <= shadow_str_d;
      shadow_dp_q  <= shadow_dp_d;
      active_str_q <= active_str_d;
      active_dp_q  <= active_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      fd_q         <= fd_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_n_o       = dp_n_q;
  assign frame_done_o = fd_q;

endmodule
